// File: rtl/local_port_input_buffer.sv
// Router local-port input stage: buffers injector packets in a small FIFO and
// presents the head word to the switch allocator with its XY output-port decode.
module local_port_input_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_W      = 2,
    parameter int DIM        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ReqUpStr,
    input  logic [DATA_WIDTH-1:0] PacketIn,
    output logic                  GntUpStr,
    output logic                  UpStrFull,
    output logic                  ReqDnStr,
    input  logic                  GntDnStr,
    input  logic                  DnStrFull,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic [2:0]            RouteOut,
    output logic [PTR_W:0]        Count
);

    localparam logic [0:0] IN_IDLE  = 1'b0;
    localparam logic [0:0] IN_GNT   = 1'b1;
    localparam logic [0:0] OUT_IDLE = 1'b0;
    localparam logic [0:0] OUT_WAIT = 1'b1;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    localparam logic [2:0] ROUTE_LOCAL = 3'd0;
    localparam logic [2:0] ROUTE_EAST  = 3'd1;
    localparam logic [2:0] ROUTE_WEST  = 3'd2;
    localparam logic [2:0] ROUTE_NORTH = 3'd3;
    localparam logic [2:0] ROUTE_SOUTH = 3'd4;

    logic [0:0]            inState;
    logic [0:0]            outState;
    logic [PTR_W-1:0]      wrPtr;
    logic [PTR_W-1:0]      rdPtr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  wrEn;
    logic                  popEn;

    // X dimension is resolved before Y; the MSB of each field gives direction.
    function automatic logic [2:0] routeDecode(input logic [DIM-1:0] xDst,
                                               input logic [DIM-1:0] yDst);
        logic [2:0] route;
        route = ROUTE_LOCAL;
        if (xDst[DIM-2:0] != '0)
            route = xDst[DIM-1] ? ROUTE_EAST : ROUTE_WEST;
        else if (yDst[DIM-2:0] != '0)
            route = yDst[DIM-1] ? ROUTE_NORTH : ROUTE_SOUTH;
        return route;
    endfunction

    // Full is judged on the registered Count, so a same-cycle pop never frees a slot.
    assign wrEn  = (inState == IN_IDLE) && ReqUpStr && (Count != FULL_CNT);
    assign popEn = (outState == OUT_WAIT) && GntDnStr;

    assign GntUpStr  = (inState == IN_GNT);
    assign ReqDnStr  = (outState == OUT_WAIT);
    assign UpStrFull = (Count == FULL_CNT);
    assign PacketOut = mem[rdPtr];
    assign RouteOut  = routeDecode(PacketOut[DATA_WIDTH-1 -: DIM],
                                   PacketOut[DATA_WIDTH-DIM-1 -: DIM]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inState <= IN_IDLE;
        end else begin
            case (inState)
                IN_IDLE: if (wrEn) inState <= IN_GNT;
                default: inState <= IN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outState <= OUT_IDLE;
        end else begin
            case (outState)
                OUT_IDLE: if ((Count != '0) && !DnStrFull) outState <= OUT_WAIT;
                default:  if (GntDnStr) outState <= OUT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            Count <= '0;
        end else begin
            if (wrEn)  wrPtr <= wrPtr + 1'b1;
            if (popEn) rdPtr <= rdPtr + 1'b1;
            case ({wrEn, popEn})
                2'b10:   Count <= Count + 1'b1;
                2'b01:   Count <= Count - 1'b1;
                default: Count <= Count;
            endcase
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (wrEn) mem[wrPtr] <= PacketIn;
    end

endmodule

// File: tb/tb_local_port_input_buffer.sv
// Bench for local_port_input_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_local_port_input_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ReqUpStr;
    logic [31:0] PacketIn;
    logic        GntUpStr;
    logic        UpStrFull;
    logic        ReqDnStr;
    logic        GntDnStr;
    logic        DnStrFull;
    logic [31:0] PacketOut;
    logic [2:0]  RouteOut;
    logic [2:0]  Count;

    int nAssert = 0;
    int nFail   = 0;

    logic [31:0] mQ[$];
    bit          mGnt;
    bit          mReq;

    local_port_input_buffer #(.DATA_WIDTH(32), .DEPTH(4), .PTR_W(2), .DIM(4)) dut (
        .clk(clk), .reset(reset), .ReqUpStr(ReqUpStr), .PacketIn(PacketIn),
        .GntUpStr(GntUpStr), .UpStrFull(UpStrFull), .ReqDnStr(ReqDnStr),
        .GntDnStr(GntDnStr), .DnStrFull(DnStrFull), .PacketOut(PacketOut),
        .RouteOut(RouteOut), .Count(Count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] expRoute(input logic [31:0] p);
        logic [3:0] x;
        logic [3:0] y;
        x = p[31:28];
        y = p[27:24];
        if (x[2:0] != 3'd0) return x[3] ? 3'd1 : 3'd2;
        if (y[2:0] != 3'd0) return y[3] ? 3'd3 : 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [31:0] mkPkt(input logic [3:0] x, input logic [3:0] y, input int id);
        return {x, y, 8'h21, 10'(id), 6'h05};
    endfunction

    task automatic modelReset();
        mQ.delete();
        mGnt = 1'b0;
        mReq = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, land on the negedge.
    task automatic tick(input logic req, input logic [31:0] pkt, input logic gnt, input logic full);
        bit acc, pop, nReq;
        ReqUpStr = req; PacketIn = pkt; GntDnStr = gnt; DnStrFull = full;
        @(posedge clk);
        acc  = !mGnt && req && (mQ.size() < 4);
        pop  = mReq && gnt;
        nReq = mReq ? !gnt : ((mQ.size() != 0) && !full);
        if (pop) void'(mQ.pop_front());
        if (acc) mQ.push_back(pkt);
        mGnt = acc;
        mReq = nReq;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (12) tick(1'b0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; ReqUpStr = 1'b0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL reset_count: got %0d want 0", Count); end
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL reset_gnt: got %b want 0", GntUpStr); end
        nAssert++; if (ReqDnStr !== 1'b0) begin nFail++; $display("FAIL reset_req: got %b want 0", ReqDnStr); end
        nAssert++; if (UpStrFull !== 1'b0) begin nFail++; $display("FAIL reset_full: got %b want 0", UpStrFull); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        tick(1'b1, 32'h3A00_0415, 1'b0, 1'b0);
        nAssert++; if (GntUpStr !== 1'b1) begin nFail++; $display("FAIL basic_gnt: got %b want 1", GntUpStr); end
        nAssert++; if (Count !== 3'd1) begin nFail++; $display("FAIL basic_count: got %0d want 1", Count); end
        nAssert++; if (ReqDnStr !== 1'b0) begin nFail++; $display("FAIL basic_req_early: got %b want 0", ReqDnStr); end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL basic_gnt_pulse: got %b want 0", GntUpStr); end
        nAssert++; if (ReqDnStr !== 1'b1) begin nFail++; $display("FAIL basic_req: got %b want 1", ReqDnStr); end
        nAssert++; if (PacketOut !== 32'h3A00_0415) begin nFail++; $display("FAIL basic_pkt: got %h want 3a000415", PacketOut); end
        nAssert++; if (RouteOut !== 3'd2) begin nFail++; $display("FAIL basic_route: got %0d want 2", RouteOut); end
        tick(1'b0, 32'h0, 1'b1, 1'b0);
        nAssert++; if (ReqDnStr !== 1'b0) begin nFail++; $display("FAIL basic_req_drop: got %b want 0", ReqDnStr); end
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL basic_pop_count: got %0d want 0", Count); end
    endtask

    task automatic test_hold_req();
        tick(1'b1, mkPkt(4'h1, 4'h0, 100), 1'b0, 1'b0);
        nAssert++; if (Count !== 3'd1) begin nFail++; $display("FAIL hold_count1: got %0d want 1", Count); end
        tick(1'b1, mkPkt(4'h2, 4'h0, 101), 1'b0, 1'b0);
        nAssert++; if (Count !== 3'd1) begin nFail++; $display("FAIL hold_count_once: got %0d want 1", Count); end
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL hold_gnt: got %b want 0", GntUpStr); end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (PacketOut !== mkPkt(4'h1, 4'h0, 100)) begin nFail++; $display("FAIL hold_pkt: got %h want %h", PacketOut, mkPkt(4'h1, 4'h0, 100)); end
        drain();
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL hold_drain: got %0d want 0", Count); end
    endtask

    task automatic test_full();
        logic [31:0] exp[4];
        int idx;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, mkPkt(4'h9, 4'h0, 200 + i), 1'b0, 1'b0);
            tick(1'b0, 32'h0, 1'b0, 1'b0);
        end
        nAssert++; if (Count !== 3'd4) begin nFail++; $display("FAIL full_count: got %0d want 4", Count); end
        nAssert++; if (UpStrFull !== 1'b1) begin nFail++; $display("FAIL full_flag: got %b want 1", UpStrFull); end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, mkPkt(4'hA, 4'h0, 204), 1'b0, 1'b0);
            nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL full_nogrant: got %b want 0", GntUpStr); end
        end
        tick(1'b1, mkPkt(4'hA, 4'h0, 204), 1'b1, 1'b0);
        nAssert++; if (Count !== 3'd3) begin nFail++; $display("FAIL full_pop_count: got %0d want 3", Count); end
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL full_same_edge_gnt: got %b want 0", GntUpStr); end
        tick(1'b1, mkPkt(4'hA, 4'h0, 204), 1'b0, 1'b0);
        nAssert++; if (GntUpStr !== 1'b1) begin nFail++; $display("FAIL full_late_gnt: got %b want 1", GntUpStr); end
        nAssert++; if (Count !== 3'd4) begin nFail++; $display("FAIL full_refill: got %0d want 4", Count); end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        exp[0] = mkPkt(4'h9, 4'h0, 201); exp[1] = mkPkt(4'h9, 4'h0, 202);
        exp[2] = mkPkt(4'h9, 4'h0, 203); exp[3] = mkPkt(4'hA, 4'h0, 204);
        idx = 0;
        for (int c = 0; c < 20 && idx < 4; c++) begin
            if (ReqDnStr) begin
                nAssert++; if (PacketOut !== exp[idx]) begin nFail++; $display("FAIL full_order%0d: got %h want %h", idx, PacketOut, exp[idx]); end
                idx++;
                tick(1'b0, 32'h0, 1'b1, 1'b0);
            end else begin
                tick(1'b0, 32'h0, 1'b0, 1'b0);
            end
        end
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL full_empty: got %0d want 0", Count); end
    endtask

    task automatic test_route();
        tick(1'b1, mkPkt(4'h0, 4'h0, 300), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (RouteOut !== 3'd0) begin nFail++; $display("FAIL route_local: got %0d want 0", RouteOut); end
        drain();
        tick(1'b1, mkPkt(4'h0, 4'h9, 301), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (RouteOut !== 3'd3) begin nFail++; $display("FAIL route_north: got %0d want 3", RouteOut); end
        drain();
        tick(1'b1, mkPkt(4'h8, 4'h2, 302), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (RouteOut !== 3'd4) begin nFail++; $display("FAIL route_south: got %0d want 4", RouteOut); end
        drain();
        tick(1'b1, mkPkt(4'hC, 4'h9, 303), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (RouteOut !== 3'd1) begin nFail++; $display("FAIL route_east: got %0d want 1", RouteOut); end
        drain();
    endtask

    task automatic test_back_to_back();
        int expId;
        tick(1'b1, mkPkt(4'h1, 4'h0, 400), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b1, mkPkt(4'h1, 4'h0, 401), 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (Count !== 3'd2) begin nFail++; $display("FAIL b2b_pre: got %0d want 2", Count); end
        tick(1'b1, mkPkt(4'h1, 4'h0, 402), 1'b1, 1'b0);
        nAssert++; if (GntUpStr !== 1'b1) begin nFail++; $display("FAIL b2b_gnt: got %b want 1", GntUpStr); end
        nAssert++; if (Count !== 3'd2) begin nFail++; $display("FAIL b2b_count: got %0d want 2", Count); end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        drain();
        expId = 1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick(1'b1, mkPkt(4'h3, 4'h0, r * 4 + i + 1), 1'b0, 1'b0);
                tick(1'b0, 32'h0, 1'b0, 1'b0);
            end
            for (int c = 0; c < 20 && Count != 3'd0; c++) begin
                if (ReqDnStr) begin
                    nAssert++; if (PacketOut[15:6] !== 10'(expId)) begin nFail++; $display("FAIL wrap_id: got %0d want %0d", PacketOut[15:6], expId); end
                    expId++;
                    tick(1'b0, 32'h0, 1'b1, 1'b0);
                end else begin
                    tick(1'b0, 32'h0, 1'b0, 1'b0);
                end
            end
        end
        nAssert++; if (expId !== 13) begin nFail++; $display("FAIL wrap_total: got %0d want 13", expId); end
    endtask

    task automatic test_dnstr_full();
        tick(1'b1, mkPkt(4'h2, 4'h0, 500), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 32'h0, 1'b0, 1'b1);
            nAssert++; if (ReqDnStr !== 1'b0) begin nFail++; $display("FAIL dnfull_noreq: got %b want 0", ReqDnStr); end
        end
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (ReqDnStr !== 1'b1) begin nFail++; $display("FAIL dnfull_req: got %b want 1", ReqDnStr); end
        tick(1'b0, 32'h0, 1'b0, 1'b1);
        nAssert++; if (ReqDnStr !== 1'b1) begin nFail++; $display("FAIL dnfull_hold: got %b want 1", ReqDnStr); end
        tick(1'b1, mkPkt(4'h2, 4'h0, 501), 1'b0, 1'b1);
        nAssert++; if (GntUpStr !== 1'b1) begin nFail++; $display("FAIL dnfull_gnt: got %b want 1", GntUpStr); end
        reset = 1'b0;
        #1;
        nAssert++; if (ReqDnStr !== 1'b0) begin nFail++; $display("FAIL async_req: got %b want 0", ReqDnStr); end
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL async_count: got %0d want 0", Count); end
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL async_gnt: got %b want 0", GntUpStr); end
        modelReset();
        ReqUpStr = 1'b0; DnStrFull = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 1'b0);
        nAssert++; if (GntUpStr !== 1'b0) begin nFail++; $display("FAIL post_reset_gnt: got %b want 0", GntUpStr); end
        nAssert++; if (Count !== 3'd0) begin nFail++; $display("FAIL post_reset_count: got %0d want 0", Count); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            tick(1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0));
            nAssert++; if (GntUpStr !== mGnt) begin nFail++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, GntUpStr, mGnt); end
            nAssert++; if (ReqDnStr !== mReq) begin nFail++; $display("FAIL rnd_req@%0d: got %b want %b", c, ReqDnStr, mReq); end
            nAssert++; if (Count !== 3'(mQ.size())) begin nFail++; $display("FAIL rnd_count@%0d: got %0d want %0d", c, Count, mQ.size()); end
            nAssert++; if (UpStrFull !== (mQ.size() == 4)) begin nFail++; $display("FAIL rnd_full@%0d: got %b want %b", c, UpStrFull, mQ.size() == 4); end
            if (mQ.size() != 0) begin
                nAssert++; if (PacketOut !== mQ[0]) begin nFail++; $display("FAIL rnd_pkt@%0d: got %h want %h", c, PacketOut, mQ[0]); end
                nAssert++; if (RouteOut !== expRoute(mQ[0])) begin nFail++; $display("FAIL rnd_route@%0d: got %0d want %0d", c, RouteOut, expRoute(mQ[0])); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_req();
        test_full();
        test_route();
        test_back_to_back();
        test_dnstr_full();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
